axi4_lite_master: RTL and testbench

AXI4-Lite initiator that turns a simple one-at-a-time command/response port into protocol-correct transactions on the S_AXI bus of the peripheral slave. It is the RTL counterpart of the bench's driver, for on-chip use: a CPU-less sequencer, a bring-up controller, or a loopback harness drives the command port. It has exactly one outstanding transaction and full independent AW/W handshaking.

---
 rtl/axi4_lite_master_if.sv | 84 ++++++++
 rtl/axi4_lite_master.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_if
//
// Purpose:
//   AXI4-Lite bus bundle between the axi4_lite_master initiator and a
//   peripheral slave. It has the five AXI4-Lite channels and no clock or
//   reset. Clock and reset stay plain ports on the modules.
//
// Parameters:
//   ADDR_WIDTH  width of AWADDR / ARADDR
//   DATA_WIDTH  width of WDATA / RDATA; the strobe width is DATA_WIDTH/8
//
// Signals (named from the master's point of view):
//   write address : awaddr, awprot, awvalid (M->S), awready (S->M)
//   write data    : wdata, wstrb, wvalid (M->S), wready (S->M)
//   write response: bresp, bvalid (S->M), bready (M->S)
//   read address  : araddr, arprot, arvalid (M->S), arready (S->M)
//   read data     : rdata, rresp, rvalid (S->M), rready (M->S)
//
// Modports:
//   master  used by the initiator
//   slave   used by a peripheral or a bench-side slave model
// ---------------------------------------------------------------------------
interface axi4_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Write address channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    // Write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    // Write response channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    // Read address channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    // Read data channel
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_master
//
// Purpose:
//   AXI4-Lite initiator. It turns a simple command/response port that
//   handles one transaction at a time into protocol-correct AXI4-Lite
//   transactions. Only one transaction is outstanding at any time. On a
//   write, the AW and W channels handshake independently of each other.
//   The command port can be driven by a CPU-less sequencer, a bring-up
//   controller or a loopback harness.
//
// Parameters:
//   ADDR_WIDTH  address width of the command port and the AXI address channels
//   DATA_WIDTH  data width; the strobe width is DATA_WIDTH/8
//
// Ports:
//   ACLK       clock; everything samples on the rising edge
//   ARESET     asynchronous reset, active high
//   cmd_valid  command present
//   cmd_ready  command accepted when high together with cmd_valid
//   cmd_write  1 = write, 0 = read
//   cmd_addr   byte address
//   cmd_wdata  write data (ignored for reads)
//   cmd_wstrb  write strobes (ignored for reads)
//   cmd_prot   protection bits (used only when AXIL_MST_PROT_EN is defined)
//   rsp_valid  response available
//   rsp_ready  response consumed when high together with rsp_valid
//   rsp_write  the response belongs to a write
//   rsp_rdata  read data; 0 for writes
//   rsp_resp   BRESP or RRESP, passed through unmodified
//   m_axi      AXI4-Lite bus, master modport
//
// Configuration macro:
//   AXIL_MST_PROT_EN  when defined, AWPROT/ARPROT carry the registered
//                     cmd_prot. When undefined, both are 3'b000 and cmd_prot
//                     is ignored. The port list is the same in both builds.
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module axi4_lite_master #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    // Command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic [2:0]            cmd_prot,

    // Response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    // AXI4-Lite bus
    axi4_lite_master_if.master    m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                state_q, state_d;

    // Handshake flags driven onto the bus and the command port
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  bready_q,    bready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rready_q,    rready_d;
    logic                  rsp_valid_q, rsp_valid_d;

    // Completion tracking for the independent AW and W channels
    logic                  aw_done_q,   aw_done_d;
    logic                  w_done_q,    w_done_d;

    // Command register. It supplies the AXI address, data and strobe outputs.
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
`ifdef AXIL_MST_PROT_EN
    logic [2:0]            prot_q,      prot_d;
`endif

    // Response register
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q,  rsp_resp_d;

    // A transfer completes only when our registered VALID/READY meets the
    // slave's side. Any slave activity on a channel we are not driving is
    // therefore ignored.
    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic rsp_hs;

    assign cmd_hs = cmd_valid   & cmd_ready_q;
    assign aw_hs  = awvalid_q   & m_axi.awready;
    assign w_hs   = wvalid_q    & m_axi.wready;
    assign b_hs   = bready_q    & m_axi.bvalid;
    assign ar_hs  = arvalid_q   & m_axi.arready;
    assign r_hs   = rready_q    & m_axi.rvalid;
    assign rsp_hs = rsp_valid_q & rsp_ready;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a hold default before the case statement. No
        // path can leave a variable unassigned, so no latch is inferred.
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
`ifdef AXIL_MST_PROT_EN
        prot_d      = prot_q;
`endif
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                // cmd_ready is 0 out of reset. It rises on the first edge
                // after reset and then stays high until a command is taken.
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
`ifdef AXIL_MST_PROT_EN
                    prot_d      = cmd_prot;
`endif
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WR_REQ: begin
                // Each VALID drops right after its own handshake. The phase
                // ends once both channels are done, in either order or in
                // the same cycle.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi.bresp;
                    state_d     = RSP;
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_resp_d  = m_axi.rresp;
                    state_d     = RSP;
                end
            end

            RSP: begin
                // The payload holds until it is consumed. No new command is
                // accepted before then.
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
`ifdef AXIL_MST_PROT_EN
            prot_q      <= '0;
`endif
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // flop then samples the pre-edge values, whatever order these
            // lines are in.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
`ifdef AXIL_MST_PROT_EN
            prot_q      <= prot_d;
`endif
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all taken directly from registers
    // -----------------------------------------------------------------------
    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    // The address register feeds both address channels. Only one of them
    // is ever valid at a time.
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

`ifdef AXIL_MST_PROT_EN
    assign m_axi.awprot  = prot_q;
    assign m_axi.arprot  = prot_q;
`else
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;

    // cmd_prot stays on the port so both builds share one port list.
    // This build deliberately does not use it.
    logic unused_cmd_prot;
    assign unused_cmd_prot = ^cmd_prot;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master
//
// Self-checking bench for axi4_lite_master. A slave model with configurable
// wait states drives the bus. Expected cycle positions and payloads come
// from the protocol timing rules, worked out with plain arithmetic for each
// transaction. Inputs are driven and outputs sampled on the falling edge.
// Cycle 0 ends at the rising edge that accepts the command.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    int checks = 0;
    int errors = 0;

    axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m_axi     (axi)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // PROT seen on the bus for a given command
    function automatic logic [2:0] exp_prot(input logic [2:0] p);
`ifdef AXIL_MST_PROT_EN
        return p;
`else
        return 3'b000 & p;
`endif
    endfunction

    // -----------------------------------------------------------------------
    // One transaction. The slave waits the given number of cycles before
    // each handshake. The response is held back for `hold` cycles.
    // -----------------------------------------------------------------------
    task automatic do_txn(input string name, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [2:0] prot,
                          input int aw_w, input int w_w, input int b_w,
                          input int ar_w, input int r_w,
                          input logic [1:0] resp, input logic [31:0] rdata,
                          input int hold);
        int e_aw_hs, e_w_hs, e_ar_hs, e_rdy_first, e_data_hs;
        int e_rsp_first, e_rsp_hs, e_cmd_rdy;
        int aw_first, aw_hs, aw_hi, w_first, w_hs, w_hi, ar_first, ar_hs, ar_hi;
        int b_first, b_hs, b_hi, r_first, r_hs, r_hi;
        int rsp_first, rsp_hs, cmd_rdy, pay_err, c, wait_n;
        int got_rdy_first, got_data_hs;
        logic [2:0]  e_prot;
        logic [31:0] e_rdata;
        bit done;

        // Reference timing: each wait state adds one cycle. A write request
        // phase ends at the later of its AW and W handshakes.
        e_prot  = exp_prot(prot);
        e_rdata = wr ? 32'h0 : rdata;
        e_aw_hs = 1 + aw_w;
        e_w_hs  = 1 + w_w;
        e_ar_hs = 1 + ar_w;
        if (wr) e_rdy_first = ((e_aw_hs > e_w_hs) ? e_aw_hs : e_w_hs) + 1;
        else    e_rdy_first = e_ar_hs + 1;
        e_data_hs   = e_rdy_first + (wr ? b_w : r_w);
        e_rsp_first = e_data_hs + 1;
        e_rsp_hs    = e_rsp_first + hold;
        e_cmd_rdy   = e_rsp_hs + 1;

        aw_first = -1; aw_hs = -1; aw_hi = 0;
        w_first  = -1; w_hs  = -1; w_hi  = 0;
        ar_first = -1; ar_hs = -1; ar_hi = 0;
        b_first  = -1; b_hs  = -1; b_hi  = 0;
        r_first  = -1; r_hs  = -1; r_hi  = 0;
        rsp_first = -1; rsp_hs = -1; cmd_rdy = -1; pay_err = 0;
        done = 1'b0;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        cmd_prot  = prot;
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge ACLK);
            wait_n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end

        c = 0;
        while (!done && c < 200) begin
            @(negedge ACLK);
            c++;
            if (c == 1) begin
                // Keep offering garbage commands so an early accept, or a
                // payload that follows the command port, would show up.
                cmd_write = 1'($urandom);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                cmd_wstrb = 4'($urandom);
                cmd_prot  = 3'($urandom);
            end

            if (axi.awvalid === 1'b1) begin
                aw_hi++;
                if (aw_first < 0) aw_first = c;
                if (axi.awaddr !== addr || axi.awprot !== e_prot) pay_err++;
                axi.awready = (aw_hi > aw_w);
                if (axi.awready) aw_hs = c;
            end else axi.awready = 1'($urandom);

            if (axi.wvalid === 1'b1) begin
                w_hi++;
                if (w_first < 0) w_first = c;
                if (axi.wdata !== wdata || axi.wstrb !== wstrb) pay_err++;
                axi.wready = (w_hi > w_w);
                if (axi.wready) w_hs = c;
            end else axi.wready = 1'($urandom);

            if (axi.arvalid === 1'b1) begin
                ar_hi++;
                if (ar_first < 0) ar_first = c;
                if (axi.araddr !== addr || axi.arprot !== e_prot) pay_err++;
                axi.arready = (ar_hi > ar_w);
                if (axi.arready) ar_hs = c;
            end else axi.arready = 1'($urandom);

            // Stray BVALID/RVALID with junk payload while READY is low must
            // be ignored.
            if (axi.bready === 1'b1) begin
                b_hi++;
                if (b_first < 0) b_first = c;
                axi.bvalid = (b_hi > b_w);
                axi.bresp  = axi.bvalid ? resp : 2'($urandom);
                if (axi.bvalid) b_hs = c;
            end else begin
                axi.bvalid = 1'($urandom);
                axi.bresp  = 2'($urandom);
            end

            if (axi.rready === 1'b1) begin
                r_hi++;
                if (r_first < 0) r_first = c;
                axi.rvalid = (r_hi > r_w);
                axi.rdata  = axi.rvalid ? rdata : $urandom;
                axi.rresp  = axi.rvalid ? resp : 2'($urandom);
                if (axi.rvalid) r_hs = c;
            end else begin
                axi.rvalid = 1'($urandom);
                axi.rdata  = $urandom;
                axi.rresp  = 2'($urandom);
            end

            if (rsp_valid === 1'b1) begin
                if (rsp_first < 0) rsp_first = c;
                if (rsp_write !== wr || rsp_rdata !== e_rdata || rsp_resp !== resp) pay_err++;
                rsp_ready = ((c - rsp_first) >= hold);
                if (rsp_ready) rsp_hs = c;
            end else rsp_ready = 1'($urandom);

            if (cmd_ready === 1'b1) begin
                cmd_rdy = c;
                done = 1'b1;
            end
        end
        if (!done) begin
            $display("FAIL %s timeout: no cmd_ready within %0d cycles", name, c);
        end

        got_rdy_first = wr ? b_first : r_first;
        got_data_hs   = wr ? b_hs : r_hs;

        if (wr) begin
            checks++;
            if (aw_first !== 1 || w_first !== 1) begin
                errors++;
                $display("FAIL %s valid_rise: aw=%0d w=%0d required 1", name, aw_first, w_first);
            end
            checks++;
            if (aw_hs !== e_aw_hs) begin
                errors++;
                $display("FAIL %s aw_handshake_cycle: got %0d required %0d", name, aw_hs, e_aw_hs);
            end
            checks++;
            if (w_hs !== e_w_hs) begin
                errors++;
                $display("FAIL %s w_handshake_cycle: got %0d required %0d", name, w_hs, e_w_hs);
            end
        end else begin
            checks++;
            if (ar_first !== 1) begin
                errors++;
                $display("FAIL %s arvalid_rise: got %0d required 1", name, ar_first);
            end
            checks++;
            if (ar_hs !== e_ar_hs) begin
                errors++;
                $display("FAIL %s ar_handshake_cycle: got %0d required %0d", name, ar_hs, e_ar_hs);
            end
        end
        checks++;
        if (aw_hi !== (wr ? e_aw_hs : 0) || w_hi !== (wr ? e_w_hs : 0) || ar_hi !== (wr ? 0 : e_ar_hs)) begin
            errors++;
            $display("FAIL %s valid_high_cycles: aw=%0d w=%0d ar=%0d required %0d %0d %0d", name,
                     aw_hi, w_hi, ar_hi, wr ? e_aw_hs : 0, wr ? e_w_hs : 0, wr ? 0 : e_ar_hs);
        end
        checks++;
        if (b_hi !== (wr ? 1 + b_w : 0) || r_hi !== (wr ? 0 : 1 + r_w)) begin
            errors++;
            $display("FAIL %s ready_high_cycles: b=%0d r=%0d required %0d %0d", name,
                     b_hi, r_hi, wr ? 1 + b_w : 0, wr ? 0 : 1 + r_w);
        end
        checks++;
        if (got_rdy_first !== e_rdy_first) begin
            errors++;
            $display("FAIL %s resp_ready_rise: got %0d required %0d", name, got_rdy_first, e_rdy_first);
        end
        checks++;
        if (got_data_hs !== e_data_hs) begin
            errors++;
            $display("FAIL %s resp_handshake_cycle: got %0d required %0d", name, got_data_hs, e_data_hs);
        end
        checks++;
        if (rsp_first !== e_rsp_first) begin
            errors++;
            $display("FAIL %s rsp_valid_rise: got %0d required %0d", name, rsp_first, e_rsp_first);
        end
        checks++;
        if (rsp_hs !== e_rsp_hs) begin
            errors++;
            $display("FAIL %s rsp_handshake_cycle: got %0d required %0d", name, rsp_hs, e_rsp_hs);
        end
        checks++;
        if (cmd_rdy !== e_cmd_rdy) begin
            errors++;
            $display("FAIL %s cmd_ready_return: got %0d required %0d", name, cmd_rdy, e_cmd_rdy);
        end
        checks++;
        if (pay_err !== 0) begin
            errors++;
            $display("FAIL %s payload: %0d bad cycles required 0 (last rsp w=%b d=%h r=%b, want w=%b d=%h r=%b)",
                     name, pay_err, rsp_write, rsp_rdata, rsp_resp, wr, e_rdata, resp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({cmd_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid,
             rsp_write, rsp_rdata, rsp_resp, axi.awaddr, axi.wdata, axi.wstrb, axi.araddr,
             axi.awprot, axi.arprot} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b%b%b%b%b%b%b addr=%h required all zero", cmd_ready,
                     axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid, axi.awaddr);
        end
        ARESET = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_cmd_ready_early: got %b required 0", cmd_ready);
        end
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_zero_wait_write();
        do_txn("zero_wait_write", 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000,
               0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    endtask

    task automatic test_aw_delay();
        do_txn("aw_delay_write", 1'b1, 32'h0000_0010, 32'hCAFE_0001, 4'h3, 3'b010,
               3, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        do_txn("w_delay_write", 1'b1, 32'h0000_0014, 32'h0BAD_F00D, 4'hC, 3'b001,
               0, 2, 1, 0, 0, 2'b11, 32'h0, 0);
    endtask

    task automatic test_read_slverr();
        do_txn("read_slverr", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000,
               0, 0, 0, 2, 1, 2'b10, 32'h1234_5678, 0);
    endtask

    task automatic test_rsp_hold();
        do_txn("rsp_hold_read", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000,
               0, 0, 0, 0, 0, 2'b01, 32'hA5A5_5A5A, 5);
        do_txn("after_hold_write", 1'b1, 32'h0000_0024, 32'h1111_2222, 4'hF, 3'b000,
               0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_txn("back_to_back", 1'(i), $urandom, $urandom, 4'($urandom), 3'($urandom),
                   0, 0, 0, 0, 0, 2'($urandom), $urandom, 0);
        end
    endtask

    task automatic test_prot();
        do_txn("prot_write", 1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, 3'b101,
               1, 1, 0, 0, 0, 2'b00, 32'h0, 0);
        do_txn("prot_read", 1'b0, 32'h0000_0034, 32'h0, 4'h0, 3'b101,
               0, 0, 0, 1, 1, 2'b00, 32'h7777_8888, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   2'($urandom), $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid();
        int wait_n;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'hFEED_FACE;
        cmd_wstrb = 4'hF;
        cmd_prot  = 3'b000;
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge ACLK);
            wait_n++;
        end
        @(negedge ACLK);
        cmd_valid   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        @(negedge ACLK);
        checks++;
        if (axi.awvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_awvalid_waiting: got %b required 1", axi.awvalid);
        end
        #2;
        ARESET = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
             rsp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_async_clear: flags=%b%b%b%b%b%b%b required 0000000", cmd_ready,
                     axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_cmd_ready_early: got %b required 0", cmd_ready);
        end
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_cmd_ready: got %b required 1", cmd_ready);
        end
        do_txn("read_after_reset", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000,
               0, 0, 0, 1, 0, 2'b00, 32'h600D_D00D, 0);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        cmd_prot    = '0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;

        test_reset();
        test_zero_wait_write();
        test_aw_delay();
        test_read_slverr();
        test_rsp_hold();
        test_back_to_back();
        test_prot();
        test_random();
        test_reset_mid();

        cmd_valid = 1'b0;
        repeat (2) @(negedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
